conv_frame_scheduler: RTL and testbench

- Sequences one image frame from pixel memory into the line-buffer controller of the 3x3 convolution path.
- Generates read addresses and throttles issue on a credit count of pixels held in the line buffers, including in-flight reads.
- Counts 3x3 windows produced downstream and reports frame completion to the top-level control, which is either a UART loader or a testbench.

---
 rtl/conv_frame_scheduler.sv | 167 ++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_scheduler.sv
// Frame read sequencer for the 3x3 convolution path: credit-throttled pixel fetch plus window counting.
// Optional stall_cycles performance counter is enabled by defining CONV_SCHED_PERF_EN.
module conv_frame_scheduler #(
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128,
    parameter int CAPACITY = 512,
    parameter int ADDR_W   = 14
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              mem_rd_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [7:0]                        mem_rd_data,
    output logic [7:0]                        pix_data,
    output logic                              pix_valid,
    input  logic                              win_valid,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(CAPACITY+1)-1:0]     occupancy
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int TOTAL     = IMG_W * IMG_H;
    localparam int WIN_TOTAL = IMG_W * (IMG_H - 2);
    localparam int OCC_W     = $clog2(CAPACITY + 1);
    localparam int ISS_W     = $clog2(TOTAL + 1);
    localparam int WIN_W     = $clog2(WIN_TOTAL + 1);

    localparam logic [OCC_W-1:0]  OCC_MAX   = OCC_W'(CAPACITY);
    localparam logic [ISS_W-1:0]  ISS_MAX   = ISS_W'(TOTAL);
    localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(WIN_TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ISS_W-1:0]  issued_q, issued_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic              pix_valid_q, pix_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              win_counted;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        issued_d     = issued_q;
        occ_d        = occ_q;
        win_cnt_d    = win_cnt_q;
        mem_rd_en_d  = 1'b0;
        win_counted  = win_valid && (state_q == S_FETCH || state_q == S_DRAIN);

        if (mem_rd_en_q && !win_counted) begin
            occ_d = occ_q + 1'b1;
        end else if (!mem_rd_en_q && win_counted && occ_q != '0) begin
            occ_d = occ_q - 1'b1;
        end

        if (win_counted && win_cnt_q != WIN_MAX) begin
            win_cnt_d = win_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    issued_d   = '0;
                    mem_addr_d = '0;
                    occ_d      = '0;
                    win_cnt_d  = '0;
                end
            end
            S_FETCH: begin
                if (mem_rd_en_q && mem_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (win_cnt_d == WIN_MAX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The issue decision is made one cycle ahead on the next-cycle credit so mem_rd_en can be a flop.
        if (state_d == S_FETCH && issued_d < ISS_MAX && occ_d < OCC_MAX) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = ADDR_W'(issued_d);
            issued_d    = issued_d + 1'b1;
        end
    end

    assign pix_valid_d  = mem_rd_en_q;
    assign busy_d       = (state_d != S_IDLE);
    assign frame_done_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            issued_q     <= '0;
            occ_q        <= '0;
            win_cnt_q    <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            issued_q     <= issued_d;
            occ_q        <= occ_d;
            win_cnt_q    <= win_cnt_d;
            pix_valid_q  <= pix_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // A stall is a fetch cycle with addresses left to issue but no credit available.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_FETCH && issued_q < ISS_MAX && occ_q == OCC_MAX && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign pix_data   = mem_rd_data;
    assign pix_valid  = pix_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Self-checking bench for conv_frame_scheduler: frame-level behavioural model, per-cycle compare, directed scenarios.
module tb_conv_frame_scheduler;

    localparam int IMG_W     = 128;
    localparam int IMG_H     = 8;
    localparam int CAPACITY  = 512;
    localparam int ADDR_W    = 14;
    localparam int OCC_W     = $clog2(CAPACITY + 1);
    localparam int TOTAL     = IMG_W * IMG_H;
    localparam int WIN_TOTAL = IMG_W * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              win_valid = 1'b0;
    logic [7:0]        mem_rd_data = 8'h00;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              busy;
    logic              frame_done;
    logic [OCC_W-1:0]  occupancy;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]       stall_cycles;
`endif

    always #5 clk = ~clk;

    conv_frame_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CAPACITY(CAPACITY), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .win_valid(win_valid),
        .busy(busy), .frame_done(frame_done), .occupancy(occupancy)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_word(input int a);
        return 8'((a * 37 + 11) ^ (a >> 5));
    endfunction

    // Pixel memory: one-cycle read latency.
    always @(posedge clk) mem_rd_data <= mem_word(int'(mem_addr));

    // Behavioural model: phase 0 idle, 1 fetch, 2 drain, 3 done.
    int     m_phase = 0;
    int     m_issued = 0;
    int     m_occ = 0;
    int     m_wins = 0;
    int     m_addr = 0;
    int     m_pix_addr = 0;
    bit     m_rd = 0;
    bit     m_pv = 0;
    bit     m_valid = 0;
    longint m_stall = 0;

    always @(posedge clk) begin
        bit counted;
        if (reset) begin
            m_phase = 0; m_issued = 0; m_occ = 0; m_wins = 0; m_addr = 0;
            m_rd = 0; m_pv = 0; m_stall = 0; m_valid = 1;
        end else begin
            if (m_rd) m_pix_addr = m_addr;
            m_pv = m_rd;
            counted = win_valid && (m_phase == 1 || m_phase == 2);
            if (m_phase == 1 && m_issued < TOTAL && m_occ == CAPACITY && m_stall < 64'hFFFF_FFFF)
                m_stall++;
            m_occ = m_occ + int'(m_rd) - int'(counted);
            if (m_occ < 0) m_occ = 0;
            if (counted && m_wins < WIN_TOTAL) m_wins++;
            case (m_phase)
                0: if (start) begin
                       m_phase = 1; m_occ = 0; m_wins = 0; m_issued = 0; m_addr = 0; m_stall = 0;
                   end
                1: if (m_rd && m_addr == TOTAL - 1) m_phase = 2;
                2: if (m_wins == WIN_TOTAL) m_phase = 3;
                default: m_phase = 0;
            endcase
            m_rd = (m_phase == 1) && (m_issued < TOTAL) && (m_occ < CAPACITY);
            if (m_rd) begin
                m_addr = m_issued;
                m_issued++;
            end
        end
    end

    // Compare process plus event tallies used by the directed checks.
    int rd_pulses = 0;
    int done_pulses = 0;
    int win_acc = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("mem_rd_en", mem_rd_en, m_rd);
            check("mem_addr", mem_addr, m_addr);
            check("pix_valid", pix_valid, m_pv);
            if (m_pv) check("pix_data", pix_data, mem_word(m_pix_addr));
            check("busy", busy, m_phase != 0);
            check("frame_done", frame_done, m_phase == 3);
            check("occupancy", occupancy, m_occ);
`ifdef CONV_SCHED_PERF_EN
            check("stall_cycles", stall_cycles, m_stall);
`endif
            if (mem_rd_en) rd_pulses++;
            if (frame_done) done_pulses++;
        end
    end

    always @(posedge clk) if (!reset && win_valid && busy && !frame_done) win_acc++;

    // Window-valid source: 0 silent, 1 line-controller model, 2 one simultaneous-event probe at occupancy 300.
    int win_mode = 0;
    bit probe_armed = 0;
    bit probe_done = 0;

    initial begin
        forever begin
            @(negedge clk);
            win_valid = 1'b0;
            case (win_mode)
                1: begin
                    if (m_phase == 1 || m_phase == 2)
                        win_valid = (m_wins < WIN_TOTAL) && (m_issued > 2 * IMG_W + m_wins)
                                    && ($urandom_range(1, 0) == 1);
                    else
                        win_valid = ($urandom_range(1, 0) == 1);
                end
                2: begin
                    if (probe_armed) begin
                        check("occ_simultaneous", occupancy, 300);
                        probe_armed = 0;
                        probe_done  = 1;
                    end else if (!probe_done && m_occ == 300) begin
                        check("rd_en_at_probe", mem_rd_en, 1);
                        win_valid   = 1'b1;
                        probe_armed = 1;
                    end
                end
                default: win_valid = 1'b0;
            endcase
        end
    end

    initial begin
        int  rd0, w0, d0;
        bit  seen;
`ifdef CONV_SCHED_PERF_EN
        longint s0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_occ", occupancy, 0);

        // Idle with stray window pulses: no reads, no credit change.
        win_mode = 1;
        rd0 = rd_pulses;
        repeat (50) @(negedge clk);
        check("idle_no_reads", rd_pulses - rd0, 0);
        check("idle_occ", occupancy, 0);

        // Fill with no windows consumed: exactly CAPACITY reads then stall.
        win_mode = 0;
        rd0 = rd_pulses;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_rd_en", mem_rd_en, 1);
        check("lat_addr", mem_addr, 0);
        check("lat_pix_valid_early", pix_valid, 0);
        @(negedge clk);
        check("lat_pix_valid", pix_valid, 1);
        repeat (598) @(negedge clk);
        check("fill_reads", rd_pulses - rd0, 512);
        check("fill_last_addr", mem_addr, 511);
        check("fill_occ", occupancy, 512);
        check("fill_rd_idle", mem_rd_en, 0);
        check("fill_busy", busy, 1);
`ifdef CONV_SCHED_PERF_EN
        check("fill_stall", stall_cycles, 87);
        s0 = stall_cycles;
        repeat (10) @(negedge clk);
        check("fill_stall_delta", stall_cycles - s0, 10);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_busy", busy, 0);
        check("rst2_occ", occupancy, 0);

        // Simultaneous read and window at occupancy 300.
        win_mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 1000 && !probe_done; c++) @(negedge clk);
        check("probe_reached", probe_done, 1);
        win_mode = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Full frame with line-controller model and a restart attempt mid-frame.
        win_mode = 1;
        rd0 = rd_pulses; w0 = win_acc; d0 = done_pulses;
        start = 1'b1;
        seen = 0;
        for (int c = 1; c <= 20000 && !seen; c++) begin
            @(negedge clk);
            start = (c == 100);
            if (c == 100) check("busy_at_restart", busy, 1);
            if (frame_done) seen = 1;
        end
        check("frame_done_seen", seen, 1);
        check("frame_last_addr", mem_addr, TOTAL - 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", busy, 0);
        check("done_single", frame_done, 0);
        check("done_start_ignored", mem_rd_en, 0);
        check("frame_reads", rd_pulses - rd0, TOTAL);
        check("frame_windows", win_acc - w0, WIN_TOTAL);
        check("frame_done_count", done_pulses - d0, 1);
        check("frame_occ_left", occupancy, TOTAL - WIN_TOTAL);
`ifdef CONV_SCHED_PERF_EN
        s0 = stall_cycles;
`endif
        repeat (20) @(negedge clk);
        check("idle_occ_hold", occupancy, TOTAL - WIN_TOTAL);
        check("idle_busy", busy, 0);
`ifdef CONV_SCHED_PERF_EN
        check("stall_hold", stall_cycles, s0);
`endif

        // Reset in the middle of a frame, then a clean restart.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            if (mem_rd_en && mem_addr == 14'd700) seen = 1;
            else @(negedge clk);
        end
        check("reached_addr_700", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_pix_valid", pix_valid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", mem_addr, 0);
        @(negedge clk);
        check("mid_rst_stays_idle", mem_rd_en, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_rd_en", mem_rd_en, 1);
        check("restart_addr", mem_addr, 0);
        seen = 0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        check("restart_frame_done", seen, 1);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
